// File: rtl/dual_cnt_sequencer_pkg.sv
// Shared types and default sizing for the dual modulo-counter run controller.
package dual_cnt_pkg;

    localparam int unsigned W_DEF       = 10;
    localparam int unsigned RST_CYC_DEF = 4;
    localparam int unsigned RUN_CYC_DEF = 28;
    localparam int unsigned CW_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        REPORT
    } state_t;

endpackage

// File: rtl/dual_cnt_sequencer_if.sv
// Result handshake bundle: totals plus status flags under valid/ready.
interface dual_cnt_sequencer_if #(
    parameter int unsigned CW = 16
);

    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_coutA;
    logic [CW-1:0] res_coutB;
    logic [CW-1:0] res_eq;
    logic          res_err;
    logic          res_aborted;

    modport master (
        output res_valid,
        output res_coutA,
        output res_coutB,
        output res_eq,
        output res_err,
        output res_aborted,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_coutA,
        input  res_coutB,
        input  res_eq,
        input  res_err,
        input  res_aborted,
        output res_ready
    );

endinterface

// File: rtl/dual_cnt_sequencer_sat_event_cnt.sv
// Saturating event counter: counts cycles where en and ev are both high.
module sat_event_cnt #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          ev,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && ev && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dual_cnt_sequencer.sv
// Run controller: holds the datapath in reset, runs it for a fixed window,
// counts carry/coincidence events and reports totals via valid/ready.
module dual_cnt_sequencer
    import dual_cnt_pkg::*;
#(
    parameter int unsigned W       = W_DEF,
    parameter int unsigned RST_CYC = RST_CYC_DEF,
    parameter int unsigned RUN_CYC = RUN_CYC_DEF,
    parameter int unsigned CW      = CW_DEF
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [W-1:0]         cfg_modA,
    input  logic [W-1:0]         cfg_modB,
    output logic                 busy,
    output logic                 dp_rst_n,
    output logic [W-1:0]         dp_modA,
    output logic [W-1:0]         dp_modB,
    input  logic                 dp_CoutA,
    input  logic                 dp_CoutB,
    input  logic                 dp_eq,
    dual_cnt_sequencer_if.master res
);

    localparam int unsigned TMAX = (RST_CYC > RUN_CYC) ? RST_CYC : RUN_CYC;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          accept;
    logic          cnt_en;
    logic          err;
    logic          aborted;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if ((cfg_modA == '0) || (cfg_modB == '0)) begin
                        state_nx = REPORT;
                    end else begin
                        state_nx = HOLD;
                        timer_nx = TW'(RST_CYC - 1);
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_nx = REPORT;
                end else if (timer == '0) begin
                    state_nx = RUN;
                    timer_nx = TW'(RUN_CYC - 1);
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            RUN: begin
                if (abort || (timer == '0)) begin
                    state_nx = REPORT;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            REPORT: begin
                if (res.res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Configuration and status flags only change on acceptance or abort,
    // so results stay frozen after the handshake until the next run.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            dp_modA <= '0;
            dp_modB <= '0;
            err     <= 1'b0;
            aborted <= 1'b0;
        end else if (accept) begin
            dp_modA <= cfg_modA;
            dp_modB <= cfg_modB;
            err     <= (cfg_modA == '0) || (cfg_modB == '0);
            aborted <= 1'b0;
        end else if (abort && ((state == HOLD) || (state == RUN))) begin
            aborted <= 1'b1;
        end
    end

    assign cnt_en = (state == RUN);

    sat_event_cnt #(.CW(CW)) u_cnt_coutA (
        .clk   (CLK),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (cnt_en),
        .ev    (dp_CoutA),
        .count (res.res_coutA)
    );

    sat_event_cnt #(.CW(CW)) u_cnt_coutB (
        .clk   (CLK),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (cnt_en),
        .ev    (dp_CoutB),
        .count (res.res_coutB)
    );

    sat_event_cnt #(.CW(CW)) u_cnt_eq (
        .clk   (CLK),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (cnt_en),
        .ev    (dp_eq),
        .count (res.res_eq)
    );

    assign busy            = (state != IDLE);
    assign dp_rst_n        = (state == RUN);
    assign res.res_valid   = (state == REPORT);
    assign res.res_err     = err;
    assign res.res_aborted = aborted;

endmodule

// File: doc/dual_cnt_sequencer.md
Name: dual_cnt_sequencer

Overview:
Run controller for the dual programmable modulo-counter datapath (counters A/B with module inputs, CoutA/CoutB carries, cntA_EQ_cntB). On a start request it latches a module pair, holds the datapath in reset, releases it for a fixed run window and counts carry and coincidence events. It then reports the totals through a valid/ready handshake. This replaces hand-sequenced reset/module stimulus, so the datapath can be exercised by firmware or a higher-level test driver.

Parameters:
W, 10, width of module values (matches datapath cntA_Module/cntB_Module).
RST_CYC, 4, cycles datapath reset is held low per run (>=1).
RUN_CYC, 28, cycles datapath runs per run (>=1).
CW, 16, width of each result event counter.

Ports:
CLK  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  run request; accepted only in IDLE.
abort  in  1  terminate active run early.
cfg_modA  in  W  module for counter A; sampled on start acceptance.
cfg_modB  in  W  module for counter B; sampled on start acceptance.
busy  out  1  high in HOLD, RUN, REPORT.
dp_rst_n  out  1  active-low reset to datapath.
dp_modA  out  W  drives datapath cntA_Module.
dp_modB  out  W  drives datapath cntB_Module.
dp_CoutA  in  1  datapath carry A.
dp_CoutB  in  1  datapath carry B.
dp_eq  in  1  datapath cntA_EQ_cntB.
res_valid  out  1  results available.
res_ready  in  1  consumer accepts results.
res_coutA  out  CW  count of RUN cycles with dp_CoutA=1.
res_coutB  out  CW  count of RUN cycles with dp_CoutB=1.
res_eq  out  CW  count of RUN cycles with dp_eq=1.
res_err  out  1  rejected configuration (module 0).
res_aborted  out  1  run ended by abort.

Behaviour:
- rst_n low (async): state=IDLE; dp_rst_n=0, dp_modA/B=0, busy=0, res_valid=0, all res_* =0, timer=0.
- All outputs are registered or decoded from the state register only. No input-to-output combinational paths.
- States: IDLE, HOLD, RUN, REPORT. dp_rst_n=1 only in RUN. busy=1 in all states except IDLE. res_valid=1 only in REPORT.
- IDLE + start:
  - Latch cfg_modA/B into dp_modA/B and clear the three counters, err and aborted.
  - If either module is 0: go to REPORT with res_err=1, counts 0, no HOLD/RUN.
  - Otherwise: go to HOLD with timer=RST_CYC-1.
- HOLD: exactly RST_CYC cycles. When timer=0, go to RUN with timer=RUN_CYC-1. Otherwise decrement timer.
- RUN: exactly RUN_CYC cycles.
  - At each RUN-cycle clock edge, increment each counter whose input is 1.
  - Counters saturate at 2^CW-1 (no wrap).
  - When timer=0, go to REPORT.
- abort in HOLD or RUN: go to REPORT next edge with res_aborted=1. Events sampled on that edge are still counted when in RUN. Abort on the final RUN cycle also sets aborted=1. abort in IDLE or REPORT is ignored.
- REPORT: res_* held stable while res_valid=1. On res_valid & res_ready, go to IDLE; res_* keep their values until the next accepted start.
- start while busy: ignored, with no queuing. cfg_* changes outside start acceptance have no effect. dp_modA/B are held constant from acceptance to the next acceptance.
- Latency: start edge to first RUN cycle = RST_CYC+1 cycles. Start edge to res_valid = RST_CYC+RUN_CYC+1 cycles.

Decomposition:
- Package dual_cnt_pkg:
  - state enum (IDLE, HOLD, RUN, REPORT)
  - default constants for W, RST_CYC, RUN_CYC, CW
- Sub-module sat_event_cnt: parameterised CW; inputs clr, en, ev; saturating. Instantiated three times.
- Timer and FSM stay in the top.

Test Plan:
Bench drives the dp_* inputs from a reference model of ideal modulo counters. Each counter starts at 0 in the first RUN cycle. Cout is high when count == module-1; eq is high when counts are equal. Defaults RST_CYC=4, RUN_CYC=28.
1. Equal modules: modA=10, modB=10, start, res_ready=1 -> dp_rst_n low 4 cycles then high 28; result coutA=2, coutB=2, eq=28, err=0, aborted=0.
2. A slower than B: modA=10, modB=5 -> coutA=2, coutB=5, eq=15. Reversed modA=5, modB=10 -> coutA=5, coutB=2, eq=15.
3. modA=5, modB=5, with res_ready held low 10 cycles -> res_valid stays high, values stable (5,5,28); IDLE one cycle after ready rises.
4. Zero module: modA=0, modB=7 -> res_valid 1 cycle after start, err=1, counts 0, dp_rst_n never high.
5. abort raised on the 10th RUN cycle with modA=modB=10 -> aborted=1, eq=10, coutA=1; a start pulse during the run is ignored.
6. rst_n dropped mid-RUN -> all outputs return to reset values immediately; the next start performs a clean run matching scenario 1.
